// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: bus width,
// FSM state encodings, the fault substitute word and the fault test.
package inst_mem_responder_pkg;

   // Width of the fetch address bus
   localparam int IMR_WIDTH = 32;

   // Word returned on a faulting fetch (MIPS sll $0,$0,0)
   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   // Responder states, 2-bit encoded
   typedef enum logic [1:0] {
      IMR_IDLE  = 2'b00,
      IMR_BUSY  = 2'b01,
      IMR_READY = 2'b10
   } imrState_t;

   // A fetch faults when it is not word aligned or lies above the array
   function automatic logic isFaultAddr(input logic [IMR_WIDTH-1:0] addr,
                                        input int depthLog2);
      return (addr[1:0] != 2'b00) || ((addr >> (depthLog2 + 2)) != '0);
   endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction word storage: 2**DEPTH_LOG2 x 32 bits, one synchronous write
// port (the load port) and one synchronous, enabled read port whose output
// register holds the response word. A read and a write to the same word on
// the same edge return the newly written data.
module inst_mem_array import inst_mem_responder_pkg::*; #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_wrAddr,
   input  logic [31:0]           i_wrData,
   input  logic                  i_rdEn,
   input  logic [DEPTH_LOG2-1:0] i_rdAddr,
   output logic [31:0]           o_rdData
);

   logic [31:0] r_mem [0:(2**DEPTH_LOG2)-1];
   logic [31:0] r_rdData;

   // Load-port write; contents survive reset so a boot image is not lost
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   // Registered read, bypassing a same-edge write so the newest data wins
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdData <= '0;
      end else if (i_rdEn) begin
         if (i_we && (i_wrAddr == i_rdAddr)) begin
            r_rdData <= i_wrData;
         end else begin
            r_rdData <= r_mem[i_rdAddr];
         end
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/inst_mem_responder.sv
// Responder side of the instruction fetch interface. A fetch is held off for
// WAIT_STATES BUSY cycles, then the word is presented for one READY cycle with
// Wait low. Faulting addresses return NOP_WORD and raise Error for that cycle.
module inst_mem_responder import inst_mem_responder_pkg::*; #(
   parameter int          WAIT_STATES = 2,
   parameter int          DEPTH_LOG2  = 10,
   parameter logic [31:0] NOP_WORD    = INST_NOP
) (
   input  logic                  p_clk,
   input  logic                  p_reset,
   input  logic [IMR_WIDTH-1:0]  p_INST_MemAddress,
   input  logic                  p_INST_MemRead,
   output logic                  p_INST_MemWait,
   output logic [31:0]           p_INST_MemDataIn,
   output logic                  p_INST_MemError,
   input  logic                  p_LD_We,
   input  logic [DEPTH_LOG2-1:0] p_LD_Addr,
   input  logic [31:0]           p_LD_Data
);

   localparam logic [3:0] CNT_RELOAD = 4'(WAIT_STATES - 1);

   imrState_t             r_state;
   imrState_t             w_nextState;
   logic [IMR_WIDTH-1:0]  r_addr;
   logic [3:0]            r_cnt;
   logic                  r_err;

   logic                  w_sameAddr;
   logic                  w_newReq;
   logic                  w_latch;
   logic                  w_dec;
   logic                  w_capture;
   logic                  w_waitFsm;
   logic                  w_fault;
   logic [DEPTH_LOG2-1:0] w_rdIdx;
   logic [31:0]           w_arrWord;

   assign w_sameAddr = (p_INST_MemAddress == r_addr);
   assign w_newReq   = p_INST_MemRead && ((r_state == IMR_IDLE) || !w_sameAddr);
   assign w_fault    = isFaultAddr(r_addr, DEPTH_LOG2);
   assign w_rdIdx    = r_addr[DEPTH_LOG2+1:2];

   // The array output register is the response word, loaded only on capture
   inst_mem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .i_clk    (p_clk),
      .i_reset  (p_reset),
      .i_we     (p_LD_We),
      .i_wrAddr (p_LD_Addr),
      .i_wrData (p_LD_Data),
      .i_rdEn   (w_capture),
      .i_rdAddr (w_rdIdx),
      .o_rdData (w_arrWord)
   );

   // Next-state and handshake decode; an address change restarts the count
   always_comb begin
      w_nextState = r_state;
      w_waitFsm   = 1'b1;
      w_latch     = 1'b0;
      w_dec       = 1'b0;
      w_capture   = 1'b0;
      unique case (r_state)
         IMR_IDLE: begin
            w_waitFsm = p_INST_MemRead;
            if (w_newReq) begin
               w_latch     = 1'b1;
               w_nextState = IMR_BUSY;
            end
         end
         IMR_BUSY: begin
            if (!p_INST_MemRead) begin
               w_nextState = IMR_IDLE;
            end else if (w_newReq) begin
               w_latch = 1'b1;
            end else if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_nextState = IMR_READY;
            end else begin
               w_dec = 1'b1;
            end
         end
         IMR_READY: begin
            w_waitFsm = !(p_INST_MemRead && w_sameAddr);
            if (w_newReq) begin
               w_latch     = 1'b1;
               w_nextState = IMR_BUSY;
            end else begin
               w_nextState = IMR_IDLE;
            end
         end
         default: begin
            w_nextState = IMR_IDLE;
         end
      endcase
   end

   // State, request address, wait counter and fault flag registers
   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         r_state <= IMR_IDLE;
         r_addr  <= '0;
         r_cnt   <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_latch) begin
            r_addr <= p_INST_MemAddress;
            r_cnt  <= CNT_RELOAD;
         end else if (w_dec) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_err <= w_fault;
         end
      end
   end

   assign p_INST_MemWait   = p_reset | w_waitFsm;
   assign p_INST_MemDataIn = r_err ? NOP_WORD : w_arrWord;
   assign p_INST_MemError  = r_err && (r_state == IMR_READY) && !p_INST_MemWait;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: an IF-like driver issues fetches and pushes the
// expected word into a scoreboard; a monitor pops and compares on every cycle
// where Read is high and Wait is low.
module tb_inst_mem_responder;

   localparam int          WS  = 2;
   localparam int          DL  = 10;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          tbReset;
   logic          tbRead;
   logic [31:0]   tbAddr;
   logic          ldWe;
   logic [DL-1:0] ldAddr;
   logic [31:0]   ldData;
   logic          memWait;
   logic [31:0]   memData;
   logic          memErr;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } expResp_t;

   expResp_t    sbQ[$];
   logic [31:0] model [0:(1<<DL)-1];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   inst_mem_responder #(
      .WAIT_STATES (WS),
      .DEPTH_LOG2  (DL),
      .NOP_WORD    (NOP)
   ) dut (
      .p_clk             (clk),
      .p_reset           (tbReset),
      .p_INST_MemAddress (tbAddr),
      .p_INST_MemRead    (tbRead),
      .p_INST_MemWait    (memWait),
      .p_INST_MemDataIn  (memData),
      .p_INST_MemError   (memErr),
      .p_LD_We           (ldWe),
      .p_LD_Addr         (ldAddr),
      .p_LD_Data         (ldData)
   );

   // One comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference answer for a byte address, straight from the memory map rules
   function automatic expResp_t expectedFor(input logic [31:0] addr);
      expResp_t e;
      e.addr = addr;
      if ((addr % 4 != 0) || (addr >= 32'(4 << DL))) begin
         e.data = NOP;
         e.err  = 1'b1;
      end else begin
         e.data = model[int'(addr / 4)];
         e.err  = 1'b0;
      end
      return e;
   endfunction

   // Monitor: every presented word must match the oldest outstanding fetch
   always @(negedge clk) begin
      expResp_t e;
      if (!tbReset) begin
         if (tbRead && !memWait) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedResp: word 0x%08h presented for addr 0x%08h, expected none outstanding", memData, tbAddr);
            end else begin
               e = sbQ.pop_front();
               checkOutput("dataIn", memData, e.data);
               checkOutput("error", {31'b0, memErr}, {31'b0, e.err});
            end
         end else begin
            checkOutput("errorGated", {31'b0, memErr}, 32'h0);
         end
      end
   end

   // Write one word through the load port and mirror it in the model
   task automatic loadWord(input int idx, input logic [31:0] val);
      ldWe   = 1'b1;
      ldAddr = idx[DL-1:0];
      ldData = val;
      model[idx] = val;
      @(posedge clk); #1;
      ldWe = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      tbRead = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Hold reset, check Wait during it and cleared outputs after it
   task automatic resetDut(input int cycles);
      tbReset = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         checkOutput("waitInReset", {31'b0, memWait}, 32'h1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      checkOutput("dataAfterReset", memData, 32'h0);
      checkOutput("errAfterReset", {31'b0, memErr}, 32'h0);
      @(posedge clk); #1;
      tbRead  = 1'b0;
      tbReset = 1'b0;
   endtask

   // IF-like fetch: hold the address until Wait drops, optionally firing a
   // load-port write loadAt cycles after the address first appears
   task automatic applyStimulus(input logic [31:0] addr, input int loadAt,
                                input int ldIdx, input logic [31:0] ldVal);
      expResp_t e;
      int       waitCycles;
      bit       done;
      tbAddr = addr;
      tbRead = 1'b1;
      if (loadAt >= 0 && loadAt <= WS) model[ldIdx] = ldVal;
      e = expectedFor(addr);
      if (loadAt > WS) model[ldIdx] = ldVal;
      sbQ.push_back(e);
      waitCycles = 0;
      done       = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (k == loadAt) begin
            ldWe   = 1'b1;
            ldAddr = ldIdx[DL-1:0];
            ldData = ldVal;
         end
         @(negedge clk);
         if (!memWait) done = 1'b1;
         else waitCycles++;
         @(posedge clk); #1;
         ldWe = 1'b0;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL fetchTimeout: addr 0x%08h got no response, required within 40 cycles", addr);
         sbQ.delete();
         tbRead = 1'b0;
      end else begin
         checkOutput("waitCycles", 32'(waitCycles), 32'(WS + 1));
      end
   endtask

   initial begin
      int          kind;
      int          hold;
      int          loadAt;
      int          ldIdx;
      logic [31:0] a;

      tbReset = 1'b1;
      tbRead  = 1'b0;
      tbAddr  = '0;
      ldWe    = 1'b0;
      ldAddr  = '0;
      ldData  = '0;

      $display("[TB] reset and preload");
      resetDut(3);
      loadWord(0, 32'h2008_0005);
      loadWord(1, 32'h2009_0007);
      loadWord(2, 32'h012A_5820);
      loadWord(3, 32'hAC0B_0010);
      for (int i = 4; i < 16; i++) loadWord(i, $urandom);
      idleCycles(1);

      $display("[TB] first fetch");
      applyStimulus(32'h0, -1, 0, 32'h0);
      idleCycles(2);

      $display("[TB] sequential fetch");
      for (int i = 0; i < 4; i++) applyStimulus(32'(i * 4), -1, 0, 32'h0);
      idleCycles(1);

      $display("[TB] address change mid-BUSY");
      tbAddr = 32'h4;
      tbRead = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      applyStimulus(32'h8, -1, 0, 32'h0);
      idleCycles(1);

      $display("[TB] faulting fetches");
      applyStimulus(32'h6, -1, 0, 32'h0);
      applyStimulus(32'h1000, -1, 0, 32'h0);
      idleCycles(1);

      $display("[TB] write-first on capture edge");
      applyStimulus(32'h8, WS, 2, 32'hDEAD_BEEF);
      idleCycles(1);

      $display("[TB] reset in BUSY");
      tbAddr = 32'h4;
      tbRead = 1'b1;
      @(posedge clk); #1;
      resetDut(2);
      idleCycles(1);
      applyStimulus(32'h0, -1, 0, 32'h0);
      idleCycles(1);

      $display("[TB] randomized fetches");
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
         end else if (kind == 1) begin
            a = (32'($urandom_range(1, 255)) << 12) | (32'($urandom_range(0, 15)) << 2);
         end else begin
            a = 32'($urandom_range(0, 15)) << 2;
         end
         if (kind == 2) begin
            tbAddr = a;
            tbRead = 1'b1;
            hold   = $urandom_range(1, WS);
            repeat (hold) begin
               @(posedge clk); #1;
            end
            idleCycles(1);
         end else begin
            loadAt = -1;
            ldIdx  = 0;
            if ($urandom_range(0, 3) == 0) begin
               loadAt = $urandom_range(0, WS + 1);
               ldIdx  = ($urandom_range(0, 1) == 0) ? int'(a[5:2]) : $urandom_range(0, 15);
            end
            applyStimulus(a, loadAt, ldIdx, $urandom);
         end
         if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
      end
      idleCycles(3);

      checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
